sirena_sched: RTL and testbench
===============================

Name: sirena_sched

Overview:
- Controller for the shared siren speaker path. Arbitrates police and ambulance siren requests and drives the 2-bit channel select of the siren output mux.
- Enforces a minimum on-time per tone and alternates tones when both are requested.
- Inserts a silent gap between tones.
- Sits between the operator inputs and the siren mux `sel` input, on the same system clock.

Parameters:
- TICK_DIV, 50000: clk_in cycles per scheduler tick (1 kHz at 50 MHz); must be ≥2.
- MIN_HOLD, 500: minimum ticks a granted tone stays on; must be ≥1.
- ALT_PERIOD, 2000: ticks per tone when both requests are active; must be ≥MIN_HOLD.
- GAP_TICKS, 50: silent ticks between tones; 0 allowed.

Ports:
- clk_in  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  global siren enable (level)
- req_pol  in  1  police tone request (level)
- req_amb  in  1  ambulance tone request (level)
- sel  out  2  mux select: 00 off, 01 police, 10 ambulance; registered
- busy  out  1  high when state ≠ IDLE; registered
- last_amb  out  1  last tone served was ambulance; registered

Behaviour:
- Reset: asynchronous on rst_n low.
  - state=IDLE, sel=00, busy=0, last_amb=0, all counters 0.
  - Reset mid-operation aborts immediately; the output is silent the same instant.
- Tick: divider counts 0..TICK_DIV-1. The tick pulse is high while div==TICK_DIV-1. The divider restarts at 0 on every state change, so durations are exact multiples of TICK_DIV.
- Counters:
  - cnt counts ticks and clears on every state change.
  - Width is $clog2(ALT_PERIOD+1); it saturates and never wraps.
  - "reaches N" means the edge where tick=1 and cnt==N-1.
- States: IDLE(sel 00), POL(01), AMB(10), GAP(00). sel is decoded from the next state and updated on the same edge as the state change. Latency is 1 clock from a sampled request to sel.
- IDLE:
  - en & req_pol -> POL.
  - else en & req_amb -> AMB.
  - When both are requested from IDLE: police if last_amb=1 or after reset, else ambulance (fair alternation).
- POL (AMB symmetric):
  - On entry: last_amb<=0 (AMB sets it to 1).
  - en=0 -> GAP on the next edge, regardless of hold (mute overrides MIN_HOLD).
  - Before cnt reaches MIN_HOLD: stay, even if the request has dropped.
  - Request dropped early: exit to GAP on the edge where cnt reaches MIN_HOLD, giving exactly MIN_HOLD×TICK_DIV clocks on.
  - After MIN_HOLD: own request low -> GAP on the next edge.
  - Both requests high: -> GAP on the edge where cnt reaches ALT_PERIOD.
- GAP:
  - Exit on the edge where cnt reaches GAP_TICKS. With GAP_TICKS=0, GAP lasts exactly 1 clock.
  - Target is re-evaluated at exit from current inputs:
    - en=0 or no request -> IDLE.
    - Only one request -> that tone.
    - Both -> the tone opposite to last_amb.
- Simultaneous events:
  - Request edge coinciding with a tick: the request is sampled that edge.
  - en falling on the same edge as a hold/alt expiry: GAP, same result.
  - A request rising during GAP is honoured at GAP exit. A request that rises and falls inside GAP is lost.
- No illegal states: a default branch returns to IDLE.

Decomposition:
- Package sirena_pkg:
  - state enum {IDLE, POL, AMB, GAP}
  - sel codes SEL_OFF=2'b00, SEL_POL=2'b01, SEL_AMB=2'b10
  - shared by the siren mux.
- Sub-module sirena_tick:
  - Parameter TICK_DIV; ports clk_in, rst_n, clr, tick.
  - Restartable divider that emits a one-cycle tick.
- Arbiter FSM and counter stay in sirena_sched.

Test Plan (TICK_DIV=4, MIN_HOLD=3, ALT_PERIOD=6, GAP_TICKS=2):
- Reset, then a 1-clock pulse on req_pol with en=1 -> sel=01 from the next edge for exactly 12 clocks, then 00 for 8 clocks (busy=1), then IDLE with busy=0; last_amb=0.
- en=1, req_pol and req_amb held high from reset -> repeating pattern: sel 01×24, 00×8, 10×24, 00×8, 01×24; last_amb toggles at each tone entry.
- In POL, drop en 5 clocks after entry (req_pol held) -> sel=00 on the next edge, GAP for 8 clocks, then IDLE; no tone while en=0.
- req_pol held 20 clocks then dropped; req_amb raised during GAP -> 01×20, 00×8, then 10 for ≥12 clocks.
- rst_n pulsed low mid-AMB (asynchronous, not clock-aligned) -> sel=00 and busy=0 immediately; after release with requests low, remains IDLE.
- GAP_TICKS=0 variant, both requests held -> 01×24, 00×1, 10×24.

Source files
------------

// File: rtl/sirena_pkg.sv
// sirena_pkg: shared state encoding and mux select codes for the siren path.
package sirena_pkg;
  typedef enum logic [1:0] {IDLE, POL, AMB, GAP} state_e;
  localparam logic [1:0] SEL_OFF = 2'b00;
  localparam logic [1:0] SEL_POL = 2'b01;
  localparam logic [1:0] SEL_AMB = 2'b10;
  function automatic logic [1:0] sel_of(state_e s);
    return s == POL ? SEL_POL : s == AMB ? SEL_AMB : SEL_OFF;
  endfunction
endpackage

// File: rtl/sirena_tick.sv
// sirena_tick: restartable divider emitting a one-cycle tick every TICK_DIV clocks.
module sirena_tick #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int DW = $clog2(TICK_DIV);
  logic [DW-1:0] div_q, div_d;
  assign tick  = div_q == DW'(TICK_DIV - 1);
  assign div_d = (clr || tick) ? '0 : div_q + 1'b1;
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
endmodule

// File: rtl/sirena_sched.sv
// sirena_sched: arbitrates police/ambulance siren requests with minimum hold,
// fair alternation and a silent gap between tones.
module sirena_sched
  import sirena_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int MIN_HOLD   = 500,
  parameter int ALT_PERIOD = 2000,
  parameter int GAP_TICKS  = 50
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       en,
  input  logic       req_pol,
  input  logic       req_amb,
  output logic [1:0] sel,
  output logic       busy,
  output logic       last_amb
);
  localparam int CW = $clog2(ALT_PERIOD + 1);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q;
  logic          busy_q, la_q, la_d, served_q, served_d;
  logic          tick, chg, both, any, hold_done, past_hold, alt_done, gap_done;
  sirena_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .clr    (chg),
    .tick   (tick)
  );
  assign both      = req_pol && req_amb;
  assign any       = req_pol || req_amb;
  assign hold_done = tick && int'(cnt_q) == MIN_HOLD - 1;
  assign past_hold = int'(cnt_q) >= MIN_HOLD;
  assign alt_done  = tick && int'(cnt_q) == ALT_PERIOD - 1;
  assign gap_done  = GAP_TICKS == 0 || (tick && int'(cnt_q) == GAP_TICKS - 1);
  assign chg       = state_d != state_q;
  // served_q distinguishes "nothing played since reset" from "police played last"
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = !en ? IDLE : both ? ((la_q || !served_q) ? POL : AMB) :
                      req_pol ? POL : req_amb ? AMB : IDLE;
      POL:  state_d = (!en || (!req_pol && (past_hold || hold_done)) || (both && alt_done)) ? GAP : POL;
      AMB:  state_d = (!en || (!req_amb && (past_hold || hold_done)) || (both && alt_done)) ? GAP : AMB;
      GAP:  state_d = !gap_done ? GAP : (!en || !any) ? IDLE :
                      both ? (la_q ? POL : AMB) : req_pol ? POL : AMB;
      default: state_d = IDLE;
    endcase
  end
  assign cnt_d    = chg ? '0 : (tick && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  assign la_d     = (chg && state_d == POL) ? 1'b0 : (chg && state_d == AMB) ? 1'b1 : la_q;
  assign served_d = served_q || (chg && (state_d == POL || state_d == AMB));
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= SEL_OFF;
      busy_q   <= 1'b0;
      la_q     <= 1'b0;
      served_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_of(state_d);
      busy_q   <= state_d != IDLE;
      la_q     <= la_d;
      served_q <= served_d;
    end
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign last_amb = la_q;
endmodule

// File: tb/tb_sirena_sched.sv
// tb_sirena_sched: segment-table stimulus with a per-cycle scoreboard against two
// scheduler instances (GAP_TICKS=2 and GAP_TICKS=0).
module tb_sirena_sched;
  logic       clk_in = 1'b0, rst_n = 1'b0, en = 1'b0, req_pol = 1'b0, req_amb = 1'b0;
  logic [1:0] sel, sel0;
  logic       busy, busy0, la, la0;
  always #5 clk_in = ~clk_in;
  sirena_sched #(.TICK_DIV(4), .MIN_HOLD(3), .ALT_PERIOD(6), .GAP_TICKS(2)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .req_pol(req_pol), .req_amb(req_amb),
    .sel(sel), .busy(busy), .last_amb(la)
  );
  sirena_sched #(.TICK_DIV(4), .MIN_HOLD(3), .ALT_PERIOD(6), .GAP_TICKS(0)) dut0 (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .req_pol(req_pol), .req_amb(req_amb),
    .sel(sel0), .busy(busy0), .last_amb(la0)
  );
  typedef struct {bit r; bit e; bit p; bit a; int n; bit d; logic [1:0] s; bit b; bit l;} seg_t;
  typedef struct {bit d; logic [1:0] s; bit b; bit l; int seg;} exp_t;
  seg_t tbl[$];
  exp_t sbq[$];
  int   tests = 0, fails = 0;
  task automatic add(input bit r, e, p, a, input int n, input bit d, input logic [1:0] s, input bit b, l);
    tbl.push_back('{r, e, p, a, n, d, s, b, l});
  endtask
  task automatic check(input string nm, input logic [1:0] gs, input logic gb, gl,
                       input logic [1:0] es, input bit eb, el);
    tests++;
    if (gs !== es || gb !== eb || gl !== el) begin
      fails++;
      $display("FAIL %s: got sel=%b busy=%b last_amb=%b, expected sel=%b busy=%b last_amb=%b",
               nm, gs, gb, gl, es, eb, el);
    end
  endtask
  task automatic do_reset();
    @(negedge clk_in);
    rst_n = 1'b0; en = 1'b0; req_pol = 1'b0; req_amb = 1'b0;
    #1;
    check("reset_dut", sel, busy, la, 2'b00, 1'b0, 1'b0);
    check("reset_dut0", sel0, busy0, la0, 2'b00, 1'b0, 1'b0);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
  endtask
  task automatic run_cycle(input bit e, p, a, d, input logic [1:0] s, input bit b, l, input int seg);
    exp_t x;
    en = e; req_pol = p; req_amb = a;
    sbq.push_back('{d, s, b, l, seg});
    @(posedge clk_in);
    #1;
    x = sbq.pop_front();
    check($sformatf("seg%0d_dut%0d", x.seg, x.d), x.d ? sel0 : sel, x.d ? busy0 : busy,
          x.d ? la0 : la, x.s, x.b, x.l);
    @(negedge clk_in);
  endtask
  initial begin
    // single police pulse, then fairness from IDLE after a served tone
    add(1, 1, 1, 0, 1,  0, 2'b01, 1, 0);
    add(0, 1, 0, 0, 11, 0, 2'b01, 1, 0);
    add(0, 1, 0, 0, 8,  0, 2'b00, 1, 0);
    add(0, 1, 0, 0, 3,  0, 2'b00, 0, 0);
    add(0, 1, 1, 1, 1,  0, 2'b10, 1, 1);
    add(0, 1, 0, 0, 11, 0, 2'b10, 1, 1);
    add(0, 1, 0, 0, 8,  0, 2'b00, 1, 1);
    add(0, 1, 0, 0, 2,  0, 2'b00, 0, 1);
    add(0, 1, 1, 1, 1,  0, 2'b01, 1, 0);
    add(0, 0, 0, 0, 8,  0, 2'b00, 1, 0);
    add(0, 0, 0, 0, 2,  0, 2'b00, 0, 0);
    // both held from reset: alternation
    add(1, 1, 1, 1, 24, 0, 2'b01, 1, 0);
    add(0, 1, 1, 1, 8,  0, 2'b00, 1, 0);
    add(0, 1, 1, 1, 24, 0, 2'b10, 1, 1);
    add(0, 1, 1, 1, 8,  0, 2'b00, 1, 1);
    add(0, 1, 1, 1, 24, 0, 2'b01, 1, 0);
    // zero-gap variant
    add(1, 1, 1, 1, 24, 1, 2'b01, 1, 0);
    add(0, 1, 1, 1, 1,  1, 2'b00, 1, 0);
    add(0, 1, 1, 1, 24, 1, 2'b10, 1, 1);
    add(0, 1, 1, 1, 1,  1, 2'b00, 1, 1);
    add(0, 1, 1, 1, 3,  1, 2'b01, 1, 0);
    // mute overrides hold
    add(1, 1, 1, 0, 5,  0, 2'b01, 1, 0);
    add(0, 0, 1, 0, 8,  0, 2'b00, 1, 0);
    add(0, 0, 1, 0, 4,  0, 2'b00, 0, 0);
    // request pulse fully inside GAP is lost
    add(1, 1, 1, 0, 1,  0, 2'b01, 1, 0);
    add(0, 1, 0, 0, 11, 0, 2'b01, 1, 0);
    add(0, 1, 0, 1, 3,  0, 2'b00, 1, 0);
    add(0, 1, 0, 0, 5,  0, 2'b00, 1, 0);
    add(0, 1, 0, 0, 3,  0, 2'b00, 0, 0);
    // police held 20 clocks, ambulance raised during GAP
    add(1, 1, 1, 0, 20, 0, 2'b01, 1, 0);
    add(0, 1, 0, 0, 2,  0, 2'b00, 1, 0);
    add(0, 1, 0, 1, 6,  0, 2'b00, 1, 0);
    add(0, 1, 0, 1, 12, 0, 2'b10, 1, 1);
    foreach (tbl[i]) begin
      if (tbl[i].r) do_reset();
      for (int c = 0; c < tbl[i].n; c++)
        run_cycle(tbl[i].e, tbl[i].p, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].b, tbl[i].l, i);
    end
    // asynchronous reset in the middle of AMB, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dut", sel, busy, la, 2'b00, 1'b0, 1'b0);
    check("async_rst_dut0", sel0, busy0, la0, 2'b00, 1'b0, 1'b0);
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) run_cycle(1, 0, 0, 0, 2'b00, 0, 0, 100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
